// File: rtl/rr_logger_pkg.sv
// ============================================================================
// rr_logger_pkg
// ----------------------------------------------------------------------------
// Purpose : Shared types and constants for the record/replay channel logger.
//           - skid_state_e : occupancy state of one registered skid stage
//           - STAT_WIDTH   : width of the optional statistics counters
//           - satInc       : saturating increment used by those counters
// Ports   : none (package)
// ============================================================================
package rr_logger_pkg;

   localparam int STAT_WIDTH = 32;

   // EMPTY holds no record, BUSY holds one, FULL holds two (head + skid).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_e;

   // Counters stick at all-ones rather than wrapping back to zero.
   function automatic logic [STAT_WIDTH-1:0] satInc(input logic [STAT_WIDTH-1:0] value);
      return (&value) ? value : value + STAT_WIDTH'(1);
   endfunction

endpackage

// File: rtl/rr_skidbuf_stage.sv
// ============================================================================
// rr_skidbuf_stage
// ----------------------------------------------------------------------------
// Purpose : One fully registered valid/ready skid stage. Both in_ready_o and
//           out_valid_o come straight from the state register, so chaining
//           stages never builds a combinational ready path.
// Params  : WIDTH       - payload width
// Ports   : clk         - clock, posedge
//           rstn        - synchronous active-low reset
//           in_valid_i  - upstream record valid
//           in_ready_o  - upstream ready (state != FULL)
//           in_data_i   - upstream record
//           out_valid_o - downstream record valid (state != EMPTY)
//           out_ready_i - downstream ready
//           out_data_o  - downstream record (oldest held record)
// ============================================================================
module rr_skidbuf_stage
   import rr_logger_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             push, pop;

   assign in_ready_o  = (state_q != FULL);
   assign out_valid_o = (state_q != EMPTY);
   assign out_data_o  = head_q;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   // head_q always presents the oldest record; skid_q only catches the one
   // record that arrives while the head is stalled.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = BUSY;
               head_d  = in_data_i;
            end
         end
         BUSY: begin
            if (push && pop) begin
               head_d = in_data_i;
            end else if (push) begin
               state_d = FULL;
               skid_d  = in_data_i;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = BUSY;
               head_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/axichannel_logger_mc.sv
// ============================================================================
// axichannel_logger_mc
// ----------------------------------------------------------------------------
// Purpose : Passes NUM_CH valid/ready channels straight through and logs the
//           begin (first visible cycle) and end (handshake) of every
//           transaction as one packed record {bmask, emask, masked data}
//           that travels through PIPE_DEPTH registered skid stages. Traced
//           channels are back-pressured whenever the log path is not ready.
// Params  : NUM_CH (1..16), DATA_WIDTH, PIPE_DEPTH (0 = pass-through)
// Ports   : clk, rstn (synchronous, active-low)
//           in_valid/in_ready/in_data     - upstream side, per channel
//           out_valid/out_ready/out_data  - downstream side, per channel
//           log_valid/log_ready           - log record handshake
//           log_bmask/log_emask/log_data  - log record payload
//           stat_records/stat_stall_cycles - only when the macro
//           AXICHANNEL_LOGGER_MC_STATS_EN is defined
// ============================================================================
module axichannel_logger_mc
   import rr_logger_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int PIPE_DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_CH-1:0]            in_valid,
   output logic [NUM_CH-1:0]            in_ready,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]            out_valid,
   input  logic [NUM_CH-1:0]            out_ready,
   output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
   output logic                         log_valid,
   input  logic                         log_ready,
   output logic [NUM_CH-1:0]            log_bmask,
   output logic [NUM_CH-1:0]            log_emask,
   output logic [NUM_CH*DATA_WIDTH-1:0] log_data
`ifdef AXICHANNEL_LOGGER_MC_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0]        stat_records,
   output logic [STAT_WIDTH-1:0]        stat_stall_cycles
`endif
);

   localparam int DW = NUM_CH * DATA_WIDTH;
   localparam int RW = 2 * NUM_CH + DW;

   logic [NUM_CH-1:0] begun_q, begun_d;
   logic [NUM_CH-1:0] beginEv, endEv;
   logic [NUM_CH-1:0] lrVec;
   logic              lr;
   logic [DW-1:0]     maskedData;
   logic              recValid;
   logic [RW-1:0]     recIn, recOut;

   assign lrVec     = {NUM_CH{lr}};
   assign out_data  = in_data;
   assign out_valid = in_valid & (begun_q | lrVec);
   assign in_ready  = out_ready & out_valid & lrVec;
   assign beginEv   = in_valid & ~begun_q & lrVec;
   assign endEv     = in_valid & in_ready;
   assign begun_d   = (begun_q | beginEv) & ~endEv;
   assign recValid  = |(beginEv | endEv);
   assign recIn     = {beginEv, endEv, maskedData};

   // Only lanes whose begin is logged in this record carry their payload.
   always_comb begin
      maskedData = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (beginEv[c]) begin
            maskedData[c*DATA_WIDTH +: DATA_WIDTH] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         begun_q <= '0;
      end else begin
         begun_q <= begun_d;
      end
   end

   // lr is gated by rstn so nothing is presented or handshaken while the
   // block is held in reset. Events only fire with lr high, so every record
   // offered to the pipeline is accepted in the same cycle.
   generate
      if (PIPE_DEPTH == 0) begin : gPass
         assign lr        = log_ready & rstn;
         assign log_valid = recValid;
         assign recOut    = recIn;
      end else begin : gPipe
         logic [PIPE_DEPTH:0] stValid;
         logic [PIPE_DEPTH:0] stReady;
         logic [RW-1:0]       stData [PIPE_DEPTH+1];

         assign stValid[0]          = recValid;
         assign stData[0]           = recIn;
         assign stReady[PIPE_DEPTH] = log_ready;
         assign lr                  = stReady[0] & rstn;
         assign log_valid           = stValid[PIPE_DEPTH];
         assign recOut              = stData[PIPE_DEPTH];

         for (genvar s = 0; s < PIPE_DEPTH; s++) begin : gStage
            rr_skidbuf_stage #(
               .WIDTH (RW)
            ) uStage (
               .clk         (clk),
               .rstn        (rstn),
               .in_valid_i  (stValid[s]),
               .in_ready_o  (stReady[s]),
               .in_data_i   (stData[s]),
               .out_valid_o (stValid[s+1]),
               .out_ready_i (stReady[s+1]),
               .out_data_o  (stData[s+1])
            );
         end
      end
   endgenerate

   assign log_bmask = recOut[RW-1 -: NUM_CH];
   assign log_emask = recOut[DW +: NUM_CH];
   assign log_data  = recOut[DW-1:0];

`ifdef AXICHANNEL_LOGGER_MC_STATS_EN
   logic [STAT_WIDTH-1:0] statRecords_q;
   logic [STAT_WIDTH-1:0] statStall_q;

   // A stall cycle is any cycle where some channel is offering data but the
   // log path is refusing new events.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         statRecords_q <= '0;
         statStall_q   <= '0;
      end else begin
         if (recValid) begin
            statRecords_q <= satInc(statRecords_q);
         end
         if ((|in_valid) && !lr) begin
            statStall_q <= satInc(statStall_q);
         end
      end
   end

   assign stat_records      = statRecords_q;
   assign stat_stall_cycles = statStall_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_axichannel_logger_mc.sv
// ============================================================================
// tb_axichannel_logger_mc
// ----------------------------------------------------------------------------
// Purpose : Self-checking bench for axichannel_logger_mc (NUM_CH=4,
//           DATA_WIDTH=32, PIPE_DEPTH=2). Directed vectors from a table,
//           hand-written multi-cycle sequences and a randomized phase, all
//           compared against a transaction-level model: an ordered queue of
//           expected log records plus per-stage occupancy counts.
//           Stat ports are checked when AXICHANNEL_LOGGER_MC_STATS_EN is set.
// ============================================================================
module tb_axichannel_logger_mc;

   localparam int NUM_CH     = 4;
   localparam int DATA_WIDTH = 32;
   localparam int PIPE_DEPTH = 2;
   localparam int DW         = NUM_CH * DATA_WIDTH;

   logic              clk;
   logic              rstn;
   logic [NUM_CH-1:0] in_valid, in_ready, out_valid, out_ready;
   logic [NUM_CH-1:0] log_bmask, log_emask;
   logic [DW-1:0]     in_data, out_data, log_data;
   logic              log_valid, log_ready;
`ifdef AXICHANNEL_LOGGER_MC_STATS_EN
   logic [31:0]       stat_records, stat_stall_cycles;
`endif

   axichannel_logger_mc #(
      .NUM_CH     (NUM_CH),
      .DATA_WIDTH (DATA_WIDTH),
      .PIPE_DEPTH (PIPE_DEPTH)
   ) dut (
      .clk               (clk),
      .rstn              (rstn),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_data          (out_data),
      .log_valid         (log_valid),
      .log_ready         (log_ready),
      .log_bmask         (log_bmask),
      .log_emask         (log_emask),
      .log_data          (log_data)
`ifdef AXICHANNEL_LOGGER_MC_STATS_EN
      ,
      .stat_records      (stat_records),
      .stat_stall_cycles (stat_stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NUM_CH-1:0] b;
      logic [NUM_CH-1:0] e;
      logic [DW-1:0]     d;
   } rec_t;

   typedef struct {
      logic [NUM_CH-1:0] inValid;
      logic [NUM_CH-1:0] outReady;
      logic [NUM_CH-1:0] expOutValid;
      logic [NUM_CH-1:0] expInReady;
      logic [NUM_CH-1:0] expB;
      logic [NUM_CH-1:0] expE;
   } vec_t;

   // Reference model state: which channels have an open logged begin, how
   // many records sit in each skid stage, and every record in flight in order.
   rec_t              expQ[$];
   logic [NUM_CH-1:0] begunM, ovM, irM, bM, eM, eLast;
   logic              lrM;
   int                cntM[PIPE_DEPTH];
   int                recordsM, stallM, popsM, obsPops;
   int                checks, errors;
   vec_t              vecs[7];
   logic [DW-1:0]     pattern;

   function automatic logic [DW-1:0] maskLanes(input logic [NUM_CH-1:0] m, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (m[c]) r[c*DATA_WIDTH +: DATA_WIDTH] = d[c*DATA_WIDTH +: DATA_WIDTH];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] r,
                                input logic lrdy, input logic [DW-1:0] d);
      in_valid  = v;
      out_ready = r;
      log_ready = lrdy;
      in_data   = d;
   endtask

   // Channel-level rules: the log path accepts when reset is released and
   // the first stage still has a free slot.
   task automatic modelEval();
      lrM = rstn && (cntM[0] < 2);
      ovM = in_valid & (begunM | {NUM_CH{lrM}});
      irM = out_ready & ovM & {NUM_CH{lrM}};
      bM  = in_valid & ~begunM & {NUM_CH{lrM}};
      eM  = in_valid & irM;
   endtask

   task automatic modelUpdate();
      int   popS[PIPE_DEPTH];
      logic push0;
      if (cntM[PIPE_DEPTH-1] > 0 && log_ready) popsM++;
      if (!rstn) begin
         begunM = '0;
         for (int s = 0; s < PIPE_DEPTH; s++) cntM[s] = 0;
         expQ.delete();
         recordsM = 0;
         stallM   = 0;
         eLast    = '0;
         return;
      end
      for (int s = 0; s < PIPE_DEPTH; s++) begin
         popS[s] = (cntM[s] > 0 && ((s == PIPE_DEPTH-1) ? log_ready : (cntM[s+1] < 2))) ? 1 : 0;
      end
      push0 = |(bM | eM);
      for (int s = 0; s < PIPE_DEPTH; s++) begin
         cntM[s] = cntM[s] + ((s == 0) ? int'(push0) : popS[s-1]) - popS[s];
      end
      if (popS[PIPE_DEPTH-1] != 0) void'(expQ.pop_front());
      if (push0) begin
         expQ.push_back('{b: bM, e: eM, d: maskLanes(bM, in_data)});
         recordsM++;
      end
      if ((|in_valid) && !lrM) stallM++;
      begunM = (begunM | bM) & ~eM;
      eLast  = eM;
   endtask

   task automatic stepCycle();
      logic expLv;
      @(negedge clk);
      modelEval();
      checkOutput("outValid", DW'(out_valid), DW'(ovM));
      checkOutput("inReady", DW'(in_ready), DW'(irM));
      checkOutput("outData", out_data, in_data);
      expLv = (cntM[PIPE_DEPTH-1] > 0);
      checkOutput("logValid", DW'(log_valid), DW'(expLv));
      if (expLv) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected a record");
         end else begin
            checkOutput("logBmask", DW'(log_bmask), DW'(expQ[0].b));
            checkOutput("logEmask", DW'(log_emask), DW'(expQ[0].e));
            checkOutput("logData", log_data, expQ[0].d);
         end
      end
      if (log_valid && log_ready) obsPops++;
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   task automatic doReset();
      rstn = 1'b0;
      applyStimulus('0, '0, 1'b0, '0);
      @(posedge clk);
      modelUpdate();
      #1;
      @(negedge clk);
      checkOutput("rstOutValid", DW'(out_valid), '0);
      checkOutput("rstInReady", DW'(in_ready), '0);
      checkOutput("rstLogValid", DW'(log_valid), '0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Upstream keeps valid and data stable until its handshake completes.
   task automatic randomDrive(input int logPct);
      logic [NUM_CH-1:0] v;
      logic [DW-1:0]     d;
      v = in_valid;
      d = in_data;
      for (int c = 0; c < NUM_CH; c++) begin
         if (!(in_valid[c] && !eLast[c])) begin
            v[c] = ($urandom_range(0, 2) != 0);
            d[c*DATA_WIDTH +: DATA_WIDTH] = $urandom;
         end
      end
      applyStimulus(v, NUM_CH'($urandom), ($urandom_range(0, 99) < logPct), d);
   endtask

   initial begin
      logic [DW-1:0] d;
      checks   = 0;
      errors   = 0;
      popsM    = 0;
      obsPops  = 0;
      recordsM = 0;
      stallM   = 0;
      begunM   = '0;
      eLast    = '0;
      for (int s = 0; s < PIPE_DEPTH; s++) cntM[s] = 0;
      rstn = 1'b0;
      applyStimulus('0, '0, 1'b0, '0);
      pattern = {32'h0000_0004, 32'h0000_0033, 32'h0000_0011, 32'h0000_00A5};

      vecs[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      vecs[1] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
      vecs[2] = '{4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
      vecs[3] = '{4'b0110, 4'b0100, 4'b0110, 4'b0100, 4'b0110, 4'b0100};
      vecs[4] = '{4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[5] = '{4'b1111, 4'b1010, 4'b1111, 4'b1010, 4'b1111, 4'b1010};
      vecs[6] = '{4'b1000, 4'b0111, 4'b1000, 4'b0000, 4'b1000, 4'b0000};

      // Each vector starts from reset: check the same-cycle channel outputs,
      // then the record two cycles later and not one cycle earlier.
      for (int i = 0; i < 7; i++) begin
         doReset();
         applyStimulus(vecs[i].inValid, vecs[i].outReady, 1'b1, pattern);
         @(negedge clk);
         checkOutput($sformatf("vec%0d outValid", i), DW'(out_valid), DW'(vecs[i].expOutValid));
         checkOutput($sformatf("vec%0d inReady", i), DW'(in_ready), DW'(vecs[i].expInReady));
         @(posedge clk);
         #1;
         applyStimulus('0, '0, 1'b1, pattern);
         @(negedge clk);
         checkOutput($sformatf("vec%0d earlyLogValid", i), DW'(log_valid), '0);
         @(posedge clk);
         #1;
         @(negedge clk);
         checkOutput($sformatf("vec%0d logValid", i), DW'(log_valid), DW'(|(vecs[i].expB | vecs[i].expE)));
         if (|(vecs[i].expB | vecs[i].expE)) begin
            checkOutput($sformatf("vec%0d bmask", i), DW'(log_bmask), DW'(vecs[i].expB));
            checkOutput($sformatf("vec%0d emask", i), DW'(log_emask), DW'(vecs[i].expE));
            checkOutput($sformatf("vec%0d data", i), log_data, maskLanes(vecs[i].expB, pattern));
         end
      end

      // Downstream stall on ch1: begin record first, end record after release.
      doReset();
      applyStimulus(4'b0010, 4'b0000, 1'b1, pattern);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("stallHold", DW'(out_valid[1]), DW'(1'b1));
      end
      applyStimulus(4'b0010, 4'b0010, 1'b1, pattern);
      stepCycle();
      applyStimulus('0, '0, 1'b1, pattern);
      for (int i = 0; i < 4; i++) stepCycle();

      // Log backpressure: fill the pipeline with single beats on ch0, then
      // ch2 must stay invisible until the log consumer drains.
      doReset();
      d = pattern;
      for (int i = 0; i < 6; i++) begin
         if (i == 0 || eLast[0]) d[DATA_WIDTH-1:0] = 32'h100 + i;
         applyStimulus(4'b0001, 4'b1111, 1'b0, d);
         stepCycle();
      end
      applyStimulus(4'b0101, 4'b1111, 1'b0, d);
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("bpOutValid2", DW'(out_valid[2]), '0);
         checkOutput("bpInReady2", DW'(in_ready[2]), '0);
      end

      // Randomized traffic continues from the stalled state.
      for (int i = 0; i < 400; i++) begin
         randomDrive(70);
         stepCycle();
      end

      // Drain: finish open transactions, then every pushed record must have
      // left through the log port.
      for (int i = 0; i < 30; i++) begin
         applyStimulus(in_valid & ~eLast, '1, 1'b1, in_data);
         stepCycle();
      end
      checkOutput("drainPops", DW'(obsPops), DW'(popsM));
      checkOutput("drainLogValid", DW'(log_valid), '0);
`ifdef AXICHANNEL_LOGGER_MC_STATS_EN
      checkOutput("statRecords", DW'(stat_records), DW'(recordsM));
      checkOutput("statStall", DW'(stat_stall_cycles), DW'(stallM));
`endif

      // Reset while ch0 is begun and stalled downstream.
      applyStimulus(4'b0001, 4'b0000, 1'b1, pattern);
      stepCycle();
      stepCycle();
      rstn = 1'b0;
      stepCycle();
      checkOutput("midRstOutValid", DW'(out_valid), '0);
      checkOutput("midRstInReady", DW'(in_ready), '0);
      checkOutput("midRstLogValid", DW'(log_valid), '0);
      rstn = 1'b1;
      applyStimulus(4'b0001, 4'b0001, 1'b1, pattern);
      stepCycle();
      applyStimulus('0, '0, 1'b1, pattern);
      stepCycle();
      checkOutput("freshLogValid", DW'(log_valid), DW'(1'b1));
      checkOutput("freshBmask", DW'(log_bmask), DW'(4'b0001));
      checkOutput("freshData", log_data, maskLanes(4'b0001, pattern));
      for (int i = 0; i < 3; i++) stepCycle();
`ifdef AXICHANNEL_LOGGER_MC_STATS_EN
      checkOutput("statRecordsFinal", DW'(stat_records), DW'(recordsM));
      checkOutput("statStallFinal", DW'(stat_stall_cycles), DW'(stallM));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
